axi_rt_budget_bank: RTL
=======================

Name: axi_rt_budget_bank

Overview:
- Bank of bandwidth-budget/period counters for the RT path, one per (channel, address region). Generalises the fixed per-region read/write counter pair.
- Supports any channel count and region count, optional carry-over of unused budget into the next period, and sticky overrun flags.
- Sits after the address decoders and the AW/AR handshake probes. It drives the isolate request into the isolation stage.

Parameters:
- NumChannels, 2, independent accounting channels (ch0 = write, ch1 = read by convention).
- NumRegions, 4, address regions per channel; must be >= 1.
- PeriodWidth, 32, width of period counters.
- BudgetWidth, 32, width of budget counters.
- BytesWidth, 12, width of per-transfer byte count; must be <= BudgetWidth.
- RegionIdxWidth, idx_width(NumRegions), derived width of the region index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- enable_i  in  1  global accounting enable.
- abort_i  in  1  one-cycle pulse; restarts every period immediately.
- carry_en_i  in  NumChannels  per-channel carry-over enable.
- ax_happening_i  in  NumChannels  handshake occurred on the channel this cycle.
- ax_region_i  in  NumChannels*RegionIdxWidth  decoded region of the transfer.
- ax_bytes_i  in  NumChannels*BytesWidth  bytes of the transfer.
- budget_i  in  NumChannels*NumRegions*BudgetWidth  budget per period.
- period_i  in  NumChannels*NumRegions*PeriodWidth  period length in cycles; 0 = never auto-reload.
- budget_left_o  out  NumChannels*NumRegions*BudgetWidth  remaining budget.
- period_left_o  out  NumChannels*NumRegions*PeriodWidth  remaining cycles.
- exhausted_o  out  NumChannels*NumRegions  budget spent.
- overrun_o  out  NumChannels*NumRegions  sticky: a transfer exceeded the remaining budget.
- isolate_o  out  1  OR of exhausted_o.

Behaviour:
- Reset: every counter is in state IDLE. budget_left_q, period_left_q, overrun_q and all outputs are 0.

Per-counter FSM with states IDLE and RUN:
- IDLE -> RUN when enable_i=1.
  - On that edge: budget_left <= budget_i, period_left <= period_i.
  - No consumption is charged in the entry cycle.
- RUN -> IDLE when enable_i=0.
  - Next cycle: budget_left, period_left and overrun are cleared to 0.
- abort_i in RUN behaves as a reload with carry-over forced off.
  - abort_i takes priority over a natural reload and over consumption in the same cycle; that transfer is dropped from accounting.
  - abort_i in IDLE is ignored.

Period counting in RUN, when period_i != 0:
- Each cycle, period_left decrements.
- In the cycle period_left_q == 1, a reload occurs next edge: period_left <= period_i.
- If period_i is reprogrammed below period_left_q, the new value takes effect at the next reload only.
- When period_i == 0, period_left stays 0 and no reload happens. Only abort_i or an enable cycle refreshes the budget.

Reload budget value:
- budget_i + (carry_en_i[c] ? min(budget_left_q - charge, budget_i) : 0).
- The addition saturates at 2^BudgetWidth-1.

Consumption:
- charge = ax_bytes_i when ax_happening_i[c] && ax_region_i[c]==r && RUN, else 0.
- A transfer in the reload cycle is charged to the expiring period before the carry-over computation.
- budget_left <= budget_left_q - charge, saturating at 0.
- If charge > budget_left_q, overrun_q <= 1.
  - overrun_q is cleared only by abort_i, leaving RUN, or reset. A natural reload does not clear it.
- A region index >= NumRegions charges nothing.

Outputs:
- exhausted_o[c][r] = RUN && budget_left_q == 0.
- isolate_o = |exhausted_o. It is combinational from registers: 0 input-to-output combinational paths, 1-cycle latency from the charging handshake.
- All outputs are registered-state-derived.

Test Plan:
- Reset and enable: rst_i high 2 cycles, then enable_i=1 with budget=256, period=10 -> after 1 cycle budget_left_o=256, period_left_o=10; exhausted_o=0.
- Consumption and exhaustion: ch0/region1 charges 128 then 128 in consecutive cycles -> budget_left 128 then 0. exhausted_o[0][1]=1 and isolate_o=1 one cycle after the second handshake. Other regions are untouched.
- Overrun: budget_left=100, charge 200 -> budget_left=0, overrun_o=1. overrun_o holds across the next natural reload and clears on an abort_i pulse.
- Carry-over: budget=100, period=5, carry_en=1, 30 charged -> at reload budget_left=170. Same test with carry_en=0 -> 100. With 0 charged -> 200, capped at 2*budget.
- Simultaneous events:
  - Charge of 40 in the period_left==1 cycle, budget_left 50, carry on -> new budget = budget_i+10.
  - abort_i in the same cycle -> budget_left=budget_i, and the charge is ignored.
- Edge modes:
  - period_i=0 -> period_left_o stays 0 and the budget never refreshes without abort.
  - enable_i dropped mid-period -> next cycle all outputs are 0.
  - rst_i asserted mid-RUN -> all counters return to IDLE with zeros on the next edge.

Source files
------------

// File: rtl/axi_rt_budget_bank_if.sv
// AW/AR handshake probe bundle feeding the RT budget bank.
// One happening bit, region index and byte count per channel.
interface axi_rt_budget_bank_if #(
    parameter int NumChannels    = 2,
    parameter int RegionIdxWidth = 2,
    parameter int BytesWidth     = 12
);
    logic [NumChannels-1:0]                ax_happening;
    logic [NumChannels*RegionIdxWidth-1:0] ax_region;
    logic [NumChannels*BytesWidth-1:0]     ax_bytes;

    modport master (
        output ax_happening,
        output ax_region,
        output ax_bytes
    );

    modport slave (
        input ax_happening,
        input ax_region,
        input ax_bytes
    );
endinterface

// File: rtl/axi_rt_budget_bank.sv
// Per-(channel, region) bandwidth budget / period counters for the RT path.
// Drives the isolate request when any running budget reaches zero.
module axi_rt_budget_bank #(
    parameter int NumChannels    = 2,
    parameter int NumRegions     = 4,
    parameter int PeriodWidth    = 32,
    parameter int BudgetWidth    = 32,
    parameter int BytesWidth     = 12,
    parameter int RegionIdxWidth = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    enable_i,
    input  logic                                    abort_i,
    input  logic [NumChannels-1:0]                  carry_en_i,
    axi_rt_budget_bank_if.slave                     ax_i,
    input  logic [NumChannels*NumRegions*BudgetWidth-1:0] budget_i,
    input  logic [NumChannels*NumRegions*PeriodWidth-1:0] period_i,
    output logic [NumChannels*NumRegions*BudgetWidth-1:0] budget_left_o,
    output logic [NumChannels*NumRegions*PeriodWidth-1:0] period_left_o,
    output logic [NumChannels*NumRegions-1:0]       exhausted_o,
    output logic [NumChannels*NumRegions-1:0]       overrun_o,
    output logic                                    isolate_o
);
    localparam int NumCnt = NumChannels * NumRegions;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e                 state_q  [NumCnt];
    state_e                 state_d  [NumCnt];
    logic [BudgetWidth-1:0] budget_q [NumCnt];
    logic [BudgetWidth-1:0] budget_d [NumCnt];
    logic [PeriodWidth-1:0] period_q [NumCnt];
    logic [PeriodWidth-1:0] period_d [NumCnt];
    logic                   overrun_q[NumCnt];
    logic                   overrun_d[NumCnt];

    always_comb begin
        int                   k;
        logic                 hit;
        logic [31:0]          rsel;
        logic [BudgetWidth-1:0] bud;
        logic [BudgetWidth-1:0] charge;
        logic [BudgetWidth-1:0] spent;
        logic [BudgetWidth-1:0] keep;
        logic [BudgetWidth:0]   sum;
        logic [PeriodWidth-1:0] per;
        for (int c = 0; c < NumChannels; c++) begin
            for (int r = 0; r < NumRegions; r++) begin
                k    = c * NumRegions + r;
                bud  = budget_i[k*BudgetWidth +: BudgetWidth];
                per  = period_i[k*PeriodWidth +: PeriodWidth];
                rsel = 32'(ax_i.ax_region[c*RegionIdxWidth +: RegionIdxWidth]);
                hit  = ax_i.ax_happening[c] && (rsel == 32'(r));
                charge = hit ?
                    BudgetWidth'(ax_i.ax_bytes[c*BytesWidth +: BytesWidth]) : '0;
                spent = (charge > budget_q[k]) ? '0 : budget_q[k] - charge;
                // Carry-over is capped at one full budget.
                keep = '0;
                if (carry_en_i[c]) begin
                    keep = (spent < bud) ? spent : bud;
                end
                sum = {1'b0, bud} + {1'b0, keep};

                state_d[k]   = state_q[k];
                budget_d[k]  = budget_q[k];
                period_d[k]  = period_q[k];
                overrun_d[k] = overrun_q[k];

                unique case (state_q[k])
                    IDLE: begin
                        if (enable_i) begin
                            state_d[k]  = RUN;
                            budget_d[k] = bud;
                            period_d[k] = per;
                        end
                    end
                    RUN: begin
                        if (!enable_i) begin
                            state_d[k]   = IDLE;
                            budget_d[k]  = '0;
                            period_d[k]  = '0;
                            overrun_d[k] = 1'b0;
                        end else if (abort_i) begin
                            budget_d[k]  = bud;
                            period_d[k]  = per;
                            overrun_d[k] = 1'b0;
                        end else begin
                            if (charge > budget_q[k]) begin
                                overrun_d[k] = 1'b1;
                            end
                            if (period_q[k] == PeriodWidth'(1)) begin
                                period_d[k] = per;
                                budget_d[k] = sum[BudgetWidth] ?
                                    '1 : sum[BudgetWidth-1:0];
                            end else begin
                                if (period_q[k] != '0) begin
                                    period_d[k] = period_q[k] - 1'b1;
                                end
                                budget_d[k] = spent;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NumCnt; k++) begin
            if (rst_i) begin
                state_q[k]   <= IDLE;
                budget_q[k]  <= '0;
                period_q[k]  <= '0;
                overrun_q[k] <= 1'b0;
            end else begin
                state_q[k]   <= state_d[k];
                budget_q[k]  <= budget_d[k];
                period_q[k]  <= period_d[k];
                overrun_q[k] <= overrun_d[k];
            end
        end
    end

    always_comb begin
        budget_left_o = '0;
        period_left_o = '0;
        exhausted_o   = '0;
        overrun_o     = '0;
        for (int k = 0; k < NumCnt; k++) begin
            budget_left_o[k*BudgetWidth +: BudgetWidth] = budget_q[k];
            period_left_o[k*PeriodWidth +: PeriodWidth] = period_q[k];
            exhausted_o[k] = (state_q[k] == RUN) && (budget_q[k] == '0);
            overrun_o[k]   = overrun_q[k];
        end
    end

    assign isolate_o = |exhausted_o;
endmodule
